gam_pattern_sequencer: RTL and testbench
========================================

# gam_pattern_sequencer

Parametrised training/recall sequencer for the GAM memory layer. Buffers up to MAX_NODES node vectors per class for MAX_CLASSES classes, then streams them class-by-class into the memory layer under its ready/wait handshake, drives `learning_done`, and switches the layer into recall mode to forward query patterns. It sits between the host/stimulus side and `Memory_Layer`/`auto_associative_recall`. It replaces testbench-side pattern feeding with synthesizable RTL.

## Interface
- `NODE_W`, 32, node vector width
- `MAX_CLASSES`, 4, number of classes; class ids are 1..MAX_CLASSES
- `MAX_NODES`, 16, pattern buffer depth per class
- `CLS_W`, $clog2(MAX_CLASSES+1), class id width
- `CNT_W`, $clog2(MAX_NODES+1), per-class count width

Ports:
- `clk` in 1 — single clock, rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `ld_valid` in 1 — load request
- `ld_ready` out 1 — load accepted when `ld_valid && ld_ready`
- `ld_class` in CLS_W — class id of loaded pattern
- `ld_data` in NODE_W — node vector to buffer
- `ld_err` out 1 — one-cycle pulse: load rejected because of a bad class id
- `start` in 1 — begin learning pass (sampled in IDLE only)
- `recall_en` in 1 — enter recall mode (sampled in LDONE only)
- `clear` in 1 — empty all buffers and return to IDLE
- `epochs` in 4 — pass count (used only with GAM_SEQ_EPOCH_EN)
- `q_valid` in 1, `q_data` in NODE_W — recall query
- `ml_ready` in 1 — memory layer ready_wait (1 = READY, 0 = WAIT)
- `x` out NODE_W — node vector to memory layer/recall
- `c` out CLS_W — class id accompanying `x`
- `x_valid` out 1 — `x`/`c` are presented
- `learning_recall` out 1 — 0 = LEARNING, 1 = RECALL
- `learning_done` out 1 — learning pass complete (level)
- `busy` out 1 — high in LEARN

## Operation
- States: IDLE, LEARN, LDONE, RECALL.
- IDLE: `ld_ready` = 1 unless the target class count equals MAX_NODES.
  - Accepted load writes `buf[ld_class][cnt]` and increments `cnt[ld_class]`.
  - `ld_class` of 0 or greater than MAX_CLASSES: the load is not written, `ld_ready` stays 1, and `ld_err` pulses.
- IDLE + `start`:
  - If every class count is 0, stay in IDLE and pulse `ld_err`.
  - Otherwise go to LEARN. Class and node pointers start at the first non-empty class, index 0.
- LEARN: present `x = buf[cls][idx]`, `c = cls`, `x_valid` = 1.
  - On `x_valid && ml_ready`: advance `idx`. At `cnt[cls]`, move to the next non-empty class; empty classes are skipped in zero cycles.
  - After the last pattern of the last non-empty class, go to LDONE.
- LDONE: `learning_done` = 1, `x_valid` = 0, `x` holds the last value. `recall_en` moves to RECALL.
- RECALL: `learning_recall` = 1, `learning_done` stays 1.
  - On `q_valid`: register `x` = `q_data`, `c` = 0, `x_valid` = 1 for one cycle. No `ml_ready` dependency.
- `clear` (any state): zero all counts, go to IDLE, drop `learning_done` and `learning_recall`. `clear` has priority over every other input in the same cycle.
- `ld_valid` outside IDLE: ignored, `ld_ready` = 0.

## Timing
- Reset values: `x` = 0, `c` = 0, `x_valid` = 0, `ld_ready` = 0, `ld_err` = 0, `learning_recall` = 0, `learning_done` = 0, `busy` = 0, all counts 0, state IDLE.
- `ld_ready` rises the first cycle after reset deasserts.
- `start` at edge N: first `x_valid` = 1 at edge N+1.
- All outputs are registered.
- Handshake at edge M: the next pattern is presented at edge M+1. One transfer per cycle while `ml_ready` stays high.
- `x`/`c` are held stable while `ml_ready` = 0.
- Final transfer at edge M: LDONE, `learning_done` = 1 and `x_valid` = 0 at edge M+1.
- `q_valid` at edge N: `x`/`x_valid` updated at edge N+1.
- Asserting `reset_n` low mid-LEARN aborts immediately. Buffer contents are lost and outputs return to reset values.

## Configuration
- `GAM_SEQ_EPOCH_EN` defined:
  - LEARN repeats the full class/node sweep `epochs` times, with `epochs` latched at `start`.
  - `epochs` = 0 is treated as 1.
  - The pointer wraps to the first non-empty class between passes with no bubble.
  - `learning_done` rises only after the final pass.
- Undefined: a single pass; `epochs` is ignored.

## Test plan
- Single class, one pass:
  - Stimulus: load class 1 with 32'h0003, 32'h0400, 32'h070005, 32'h0101, 32'h0c0b0a09, 32'h0604, 32'h060002, 32'h0202; `start`; `ml_ready` held 1.
  - Response: 8 consecutive transfers in load order with `c` = 1, then `learning_done` = 1 the next cycle.
- Wait stall:
  - Stimulus: toggle `ml_ready` 1,0,0,1 during LEARN.
  - Response: `x` held unchanged across the WAIT cycles; no pattern lost or duplicated.
- Empty-class skip and bad ids:
  - Stimulus: load classes 1 and 3 only, plus one load with `ld_class` = 0.
  - Response: `ld_err` pulses once; stream goes class 1 directly to class 3; `start` with all counts 0 pulses `ld_err` and stays in IDLE.
- Full buffer:
  - Stimulus: load MAX_NODES patterns into class 2.
  - Response: `ld_ready` = 0 for class 2 while loads to class 1 are still accepted.
- Recall:
  - Stimulus: after LDONE, `recall_en`, then `q_valid` with `q_data` = 32'h070005.
  - Response: `learning_recall` = 1; `x` = 32'h070005 with `x_valid` for one cycle.
- Reset/clear mid-LEARN:
  - Stimulus: `reset_n` low at transfer 3.
  - Response: all outputs return to reset values and IDLE; a subsequent `start` pulses `ld_err`.
  - Stimulus: `clear` in the same cycle as `start`.
  - Response: state stays IDLE.
  - With GAM_SEQ_EPOCH_EN: `epochs` = 3 yields 24 transfers for the 8-pattern set.

Source files
------------

// File: rtl/gam_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// gam_pattern_sequencer
//
// Training/recall sequencer for the GAM memory layer. Node vectors are
// buffered per class (class ids 1..MAX_CLASSES, up to MAX_NODES each) while
// idle. A start request then streams every buffered vector, class by class
// in ascending id order, into the memory layer under its ready/wait
// handshake. Once the sweep is done, learning_done is raised. A recall
// request then switches the layer into recall mode and forwards query
// vectors.
//
// Optional feature (compile-time macro):
//   GAM_SEQ_EPOCH_EN - repeat the full sweep 'epochs' times (0 counts as 1),
//                      with 'epochs' latched at start. When the macro is
//                      undefined, a single sweep is made and 'epochs' is
//                      ignored.
//
// Ports:
//   clk             in   single clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   ld_valid        in   load request
//   ld_ready        out  load accepted when ld_valid && ld_ready
//   ld_class        in   class id of the loaded vector
//   ld_data         in   node vector to buffer
//   ld_err          out  one-cycle pulse: bad class id, or start with
//                        nothing loaded
//   start           in   begin learning pass (sampled in IDLE)
//   recall_en       in   enter recall mode (sampled in LDONE)
//   clear           in   empty all buffers and return to IDLE (top priority)
//   epochs          in   pass count (GAM_SEQ_EPOCH_EN only)
//   q_valid/q_data  in   recall query
//   ml_ready        in   memory layer ready_wait (1 = READY, 0 = WAIT)
//   x, c, x_valid   out  node vector, class id and presentation flag
//   learning_recall out  0 = LEARNING, 1 = RECALL
//   learning_done   out  learning pass complete (level)
//   busy            out  high while streaming (LEARN)
// ---------------------------------------------------------------------------
module gam_pattern_sequencer #(
  parameter int NODE_W      = 32,
  parameter int MAX_CLASSES = 4,
  parameter int MAX_NODES   = 16,
  parameter int CLS_W       = $clog2(MAX_CLASSES + 1),
  parameter int CNT_W       = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CLS_W-1:0]  ld_class,
  input  logic [NODE_W-1:0] ld_data,
  output logic              ld_err,
  input  logic              start,
  input  logic              recall_en,
  input  logic              clear,
  input  logic [3:0]        epochs,
  input  logic              q_valid,
  input  logic [NODE_W-1:0] q_data,
  input  logic              ml_ready,
  output logic [NODE_W-1:0] x,
  output logic [CLS_W-1:0]  c,
  output logic              x_valid,
  output logic              learning_recall,
  output logic              learning_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_learn  = 2'd1,
    st_ldone  = 2'd2,
    st_recall = 2'd3
  } state_t;

  state_t state;

  // Pattern storage and per-class fill counts (index = class id).
  logic [NODE_W-1:0] pbuf [1:MAX_CLASSES][0:MAX_NODES-1];
  logic [CNT_W-1:0]  cnt  [1:MAX_CLASSES];

  // Streaming pointers: current class and node index within that class.
  logic [CLS_W-1:0]  cls;
  logic [CNT_W-1:0]  idx;

  // Registered "loads are open" flag; high exactly while in IDLE.
  logic              ready_q;

  logic              ld_cls_ok;
  logic              ld_sel_full;
  logic              ld_wr;
  logic              ld_bad;

  logic              any_nonempty;
  logic [CLS_W-1:0]  first_cls;
  logic [CLS_W-1:0]  next_cls;
  logic              next_found;
  logic [CNT_W-1:0]  cur_cnt;

  logic [CLS_W-1:0]  rd_cls;
  logic [CNT_W-1:0]  rd_idx;
  logic [NODE_W-1:0] rd_data;
  logic              end_of_pass;
  logic              more_passes;

`ifdef GAM_SEQ_EPOCH_EN
  logic [3:0]        epoch_left;
  assign more_passes = (epoch_left > 4'd1);
`else
  logic              unused_epochs;
  assign more_passes   = 1'b0;
  assign unused_epochs = ^epochs;
`endif

  // Load decode. The ready flag is registered, but the "target class is
  // full" term must follow ld_class in the same cycle. Without that, a
  // producer could not see class 2 as full while class 1 still accepts.
  // Bad class ids never count as full, so they are accepted and rejected
  // through ld_err.
  always_comb begin
    ld_cls_ok   = (ld_class != '0) && (ld_class <= CLS_W'(MAX_CLASSES));
    ld_sel_full = 1'b0;
    for (int k = 1; k <= MAX_CLASSES; k++) begin
      if ((ld_class == CLS_W'(k)) && (cnt[k] == CNT_W'(MAX_NODES)))
        ld_sel_full = 1'b1;
    end
  end

  assign ld_ready = ready_q && !ld_sel_full;
  assign ld_wr    = ld_valid && ld_ready && ld_cls_ok && !clear;
  assign ld_bad   = ld_valid && ld_ready && !ld_cls_ok && !clear;

  // Class scan. The loop runs from the top id down, so the lowest
  // qualifying id wins. This yields the first non-empty class overall and
  // the next non-empty class above the current one. Empty classes therefore
  // cost no cycles in the stream.
  always_comb begin
    any_nonempty = 1'b0;
    first_cls    = '0;
    next_cls     = '0;
    next_found   = 1'b0;
    cur_cnt      = '0;
    for (int k = MAX_CLASSES; k >= 1; k--) begin
      if (cnt[k] != '0) begin
        any_nonempty = 1'b1;
        first_cls    = CLS_W'(k);
        if (CLS_W'(k) > cls) begin
          next_found = 1'b1;
          next_cls   = CLS_W'(k);
        end
      end
      if (cls == CLS_W'(k))
        cur_cnt = cnt[k];
    end
  end

  // Address of the vector to present after the current one (or the first
  // vector when starting from IDLE). Wrapping back to the first class marks
  // the end of a sweep. The same wrap address is used for the next epoch,
  // so passes run back to back with no bubble.
  always_comb begin
    rd_cls      = first_cls;
    rd_idx      = '0;
    end_of_pass = 1'b0;
    if (state != st_idle) begin
      if ((idx + CNT_W'(1)) < cur_cnt) begin
        rd_cls = cls;
        rd_idx = idx + CNT_W'(1);
      end else if (next_found) begin
        rd_cls = next_cls;
        rd_idx = '0;
      end else begin
        end_of_pass = 1'b1;
      end
    end
  end

  // Buffer read mux.
  always_comb begin
    rd_data = '0;
    for (int k = 1; k <= MAX_CLASSES; k++) begin
      for (int n = 0; n < MAX_NODES; n++) begin
        if ((rd_cls == CLS_W'(k)) && (rd_idx == CNT_W'(n)))
          rd_data = pbuf[k][n];
      end
    end
  end

  // Buffer write. The storage is not reset: clearing the counts is enough
  // to make every old entry unreachable.
  always_ff @(posedge clk) begin
    if (ld_wr) begin
      for (int k = 1; k <= MAX_CLASSES; k++) begin
        for (int n = 0; n < MAX_NODES; n++) begin
          if ((ld_class == CLS_W'(k)) && (cnt[k] == CNT_W'(n)))
            pbuf[k][n] <= ld_data;
        end
      end
    end
  end

  // Control FSM with registered outputs. Clear overrides everything else
  // in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= st_idle;
      for (int k = 1; k <= MAX_CLASSES; k++)
        cnt[k] <= '0;
      cls             <= '0;
      idx             <= '0;
      ready_q         <= 1'b0;
      x               <= '0;
      c               <= '0;
      x_valid         <= 1'b0;
      ld_err          <= 1'b0;
      learning_recall <= 1'b0;
      learning_done   <= 1'b0;
      busy            <= 1'b0;
`ifdef GAM_SEQ_EPOCH_EN
      epoch_left      <= 4'd1;
`endif
    end else begin
      ld_err <= 1'b0;
      if (clear) begin
        state           <= st_idle;
        for (int k = 1; k <= MAX_CLASSES; k++)
          cnt[k] <= '0;
        ready_q         <= 1'b1;
        x_valid         <= 1'b0;
        learning_recall <= 1'b0;
        learning_done   <= 1'b0;
        busy            <= 1'b0;
      end else begin
        case (state)
          st_idle: begin
            ready_q <= 1'b1;
            if (ld_wr) begin
              for (int k = 1; k <= MAX_CLASSES; k++) begin
                if (ld_class == CLS_W'(k))
                  cnt[k] <= cnt[k] + CNT_W'(1);
              end
            end
            if (ld_bad)
              ld_err <= 1'b1;
            if (start) begin
              if (!any_nonempty) begin
                ld_err <= 1'b1;
              end else begin
                state   <= st_learn;
                ready_q <= 1'b0;
                busy    <= 1'b1;
                cls     <= rd_cls;
                idx     <= rd_idx;
                x       <= rd_data;
                c       <= rd_cls;
                x_valid <= 1'b1;
`ifdef GAM_SEQ_EPOCH_EN
                epoch_left <= (epochs == 4'd0) ? 4'd1 : epochs;
`endif
              end
            end
          end

          st_learn: begin
            if (ml_ready) begin
              if (end_of_pass && !more_passes) begin
                state         <= st_ldone;
                x_valid       <= 1'b0;
                busy          <= 1'b0;
                learning_done <= 1'b1;
              end else begin
                cls <= rd_cls;
                idx <= rd_idx;
                x   <= rd_data;
                c   <= rd_cls;
`ifdef GAM_SEQ_EPOCH_EN
                if (end_of_pass)
                  epoch_left <= epoch_left - 4'd1;
`endif
              end
            end
          end

          st_ldone: begin
            if (recall_en) begin
              state           <= st_recall;
              learning_recall <= 1'b1;
            end
          end

          st_recall: begin
            x_valid <= q_valid;
            if (q_valid) begin
              x <= q_data;
              c <= '0;
            end
          end

          default: state <= st_idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gam_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gam_pattern_sequencer
//
// Directed-plus-random bench for gam_pattern_sequencer. A reference model
// keeps per-class lists of the accepted vectors. From these lists it builds
// the expected learning stream (passes x classes ascending x load order),
// and the DUT output is checked against that stream transfer by transfer.
// ---------------------------------------------------------------------------
module tb_gam_pattern_sequencer;

  localparam int NODE_W      = 32;
  localparam int MAX_CLASSES = 4;
  localparam int MAX_NODES   = 16;
  localparam int CLS_W       = 3;
  localparam int CNT_W       = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ld_valid;
  logic              ld_ready;
  logic [CLS_W-1:0]  ld_class;
  logic [NODE_W-1:0] ld_data;
  logic              ld_err;
  logic              start;
  logic              recall_en;
  logic              clear;
  logic [3:0]        epochs;
  logic              q_valid;
  logic [NODE_W-1:0] q_data;
  logic              ml_ready;
  logic [NODE_W-1:0] x;
  logic [CLS_W-1:0]  c;
  logic              x_valid;
  logic              learning_recall;
  logic              learning_done;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: accepted vectors per class id, in load order.
  logic [31:0] mdata [8][MAX_NODES];
  int          msize [8];

  // Expected learning stream.
  logic [31:0] ex_q [$];
  logic [2:0]  ec_q [$];

  logic [31:0] tv [8] = '{32'h0003, 32'h0400, 32'h070005, 32'h0101,
                          32'h0c0b0a09, 32'h0604, 32'h060002, 32'h0202};

  gam_pattern_sequencer #(
    .NODE_W(NODE_W), .MAX_CLASSES(MAX_CLASSES), .MAX_NODES(MAX_NODES),
    .CLS_W(CLS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_class(ld_class),
    .ld_data(ld_data), .ld_err(ld_err),
    .start(start), .recall_en(recall_en), .clear(clear), .epochs(epochs),
    .q_valid(q_valid), .q_data(q_data), .ml_ready(ml_ready),
    .x(x), .c(c), .x_valid(x_valid),
    .learning_recall(learning_recall), .learning_done(learning_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) msize[k] = 0;
  endtask

  function automatic int n_passes();
`ifdef GAM_SEQ_EPOCH_EN
    return (epochs == 4'd0) ? 1 : int'(epochs);
`else
    return 1;
`endif
  endfunction

  task automatic build_expected();
    ex_q.delete();
    ec_q.delete();
    for (int p = 0; p < n_passes(); p++)
      for (int k = 1; k <= MAX_CLASSES; k++)
        for (int i = 0; i < msize[k]; i++) begin
          ex_q.push_back(mdata[k][i]);
          ec_q.push_back(3'(k));
        end
  endtask

  // One load attempt; ld_ready and ld_err are checked against the model.
  task automatic apply_stimulus(input logic [2:0] cls, input logic [31:0] d);
    logic bad, exp_rdy;
    bad     = (cls == 3'd0) || (int'(cls) > MAX_CLASSES);
    exp_rdy = bad || (msize[cls] < MAX_NODES);
    ld_valid = 1'b1;
    ld_class = cls;
    ld_data  = d;
    #1;
    check_output("ld_ready", ld_ready, exp_rdy);
    step();
    ld_valid = 1'b0;
    check_output("ld_err", ld_err, bad && exp_rdy);
    if (exp_rdy && !bad) begin
      mdata[cls][msize[cls]] = d;
      msize[cls]++;
    end
  endtask

  // Start a pass and follow the stream. mode 0: ml_ready always 1,
  // mode 1: random ml_ready, mode 2: ml_ready pattern 1,0,0,1.
  task automatic run_learn(input int mode);
    int          budget;
    int          cyc;
    logic [31:0] last_x;
    logic [2:0]  last_c;
    build_expected();
    last_x = ex_q[ex_q.size()-1];
    last_c = ec_q[ec_q.size()-1];
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 1000;
    cyc = 0;
    while (ex_q.size() > 0 && budget > 0) begin
      check_output("x_valid_learn", x_valid, 1'b1);
      check_output("busy_learn", busy, 1'b1);
      check_output("x_stream", x, ex_q[0]);
      check_output("c_stream", c, ec_q[0]);
      case (mode)
        0: ml_ready = 1'b1;
        1: ml_ready = 1'($urandom_range(0, 1));
        default: ml_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      step();
      if (ml_ready) begin
        void'(ex_q.pop_front());
        void'(ec_q.pop_front());
      end
      cyc++;
      budget--;
    end
    ml_ready = 1'b0;
    if (ex_q.size() > 0)
      check_output("learn_timeout", ex_q.size(), 0);
    check_output("learning_done", learning_done, 1'b1);
    check_output("x_valid_ldone", x_valid, 1'b0);
    check_output("busy_ldone", busy, 1'b0);
    check_output("x_hold_ldone", x, last_x);
    check_output("c_hold_ldone", c, last_c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_x"}, x, 32'h0);
    check_output({tag, "_c"}, c, 32'h0);
    check_output({tag, "_x_valid"}, x_valid, 1'b0);
    check_output({tag, "_ld_ready"}, ld_ready, 1'b0);
    check_output({tag, "_ld_err"}, ld_err, 1'b0);
    check_output({tag, "_learning_recall"}, learning_recall, 1'b0);
    check_output({tag, "_learning_done"}, learning_done, 1'b0);
    check_output({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    ld_class = 3'd1;
    #1;
    check_output("clr_ld_ready", ld_ready, 1'b1);
    check_output("clr_learning_done", learning_done, 1'b0);
    check_output("clr_learning_recall", learning_recall, 1'b0);
    check_output("clr_x_valid", x_valid, 1'b0);
  endtask

  task automatic check_empty_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output({tag, "_ld_err"}, ld_err, 1'b1);
    check_output({tag, "_busy"}, busy, 1'b0);
    check_output({tag, "_x_valid"}, x_valid, 1'b0);
    step();
    check_output({tag, "_ld_err_drop"}, ld_err, 1'b0);
    check_output({tag, "_still_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; ld_valid = 1'b0; ld_class = 3'd1; ld_data = '0;
    start = 1'b0; recall_en = 1'b0; clear = 1'b0; epochs = 4'd0;
    q_valid = 1'b0; q_data = '0; ml_ready = 1'b0;
    model_clear();

    // Reset values, then ld_ready rising one cycle after release.
    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();
    check_output("ld_ready_after_reset", ld_ready, 1'b1);

    // Single class, eight patterns, ml_ready held high.
    $display("[TB] single class stream");
    epochs = 4'd3;
    for (int i = 0; i < 8; i++) apply_stimulus(3'd1, tv[i]);
    run_learn(0);

    // Recall: forward a query and drop x_valid the cycle after.
    $display("[TB] recall");
    recall_en = 1'b1;
    step();
    recall_en = 1'b0;
    check_output("learning_recall", learning_recall, 1'b1);
    check_output("learning_done_recall", learning_done, 1'b1);
    ld_class = 3'd1;
    #1;
    check_output("ld_ready_recall", ld_ready, 1'b0);
    q_valid = 1'b1;
    q_data  = 32'h070005;
    step();
    q_valid = 1'b0;
    check_output("q_x", x, 32'h070005);
    check_output("q_c", c, 32'h0);
    check_output("q_x_valid", x_valid, 1'b1);
    step();
    check_output("q_x_valid_drop", x_valid, 1'b0);
    check_output("q_x_hold", x, 32'h070005);

    do_clear();
    check_empty_start("empty_start");

    // Classes 1 and 3 only, bad ids, 1,0,0,1 stall pattern.
    $display("[TB] empty-class skip and bad ids");
    for (int i = 0; i < int'($urandom_range(1, 5)); i++)
      apply_stimulus(3'd1, $urandom);
    apply_stimulus(3'd0, $urandom);
    step();
    check_output("ld_err_once", ld_err, 1'b0);
    for (int i = 0; i < int'($urandom_range(1, 5)); i++)
      apply_stimulus(3'd3, $urandom);
    apply_stimulus(3'd7, $urandom);
    epochs = 4'($urandom_range(0, 3));
    run_learn(2);

    // Full buffer in class 2 while other classes still accept.
    $display("[TB] full buffer");
    do_clear();
    for (int i = 0; i < MAX_NODES; i++) apply_stimulus(3'd2, $urandom);
    apply_stimulus(3'd2, $urandom);
    apply_stimulus(3'd1, $urandom);
    apply_stimulus(3'd4, $urandom);
    epochs = 4'($urandom_range(0, 2));
    run_learn(1);

    // Reset asserted while the third transfer is presented.
    $display("[TB] reset mid-learn");
    do_clear();
    epochs = 4'd1;
    for (int i = 0; i < 8; i++) apply_stimulus(3'd1, tv[i]);
    start = 1'b1;
    step();
    start = 1'b0;
    ml_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("pre_reset_x", x, tv[i]);
      if (i < 2) step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    ml_ready = 1'b0;
    check_reset_outputs("async_reset");
    step();
    reset_n = 1'b1;
    model_clear();
    step();
    check_empty_start("start_after_reset");

    // Clear and start in the same cycle: stays idle with empty buffers.
    $display("[TB] clear with start");
    apply_stimulus(3'd2, $urandom);
    apply_stimulus(3'd3, $urandom);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    model_clear();
    check_output("clr_start_busy", busy, 1'b0);
    check_output("clr_start_x_valid", x_valid, 1'b0);
    check_output("clr_start_ld_err", ld_err, 1'b0);
    check_empty_start("start_after_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
